// File: rtl/sqrt_seq_if.sv
// sqrt_seq_if: valid/ready request and response bundle for the sequential square-root unit.
// The producer/consumer side uses the master modport; the unit itself uses the slave modport.
interface sqrt_seq_if #(
    parameter int IN_W   = 8,
    parameter int FRAC_W = 12
) ();
    localparam int OUT_W = IN_W / 2 + FRAC_W;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out;
    logic [OUT_W:0]   rem;
    logic             exact;

    modport master (
        output in_valid, in, out_ready,
        input  in_ready, out_valid, out, rem, exact
    );

    modport slave (
        input  in_valid, in, out_ready,
        output in_ready, out_valid, out, rem, exact
    );
endinterface

// File: rtl/sqrt_seq.sv
// sqrt_seq: sequential fixed-point square root, one result bit per clock (radix-2 digit recurrence).
// Result is unsigned Q(IN_W/2).(FRAC_W); rem/exact always describe the floor root.
// Optional feature macro: SQRT_ROUND_EN adds an RND state that rounds `out` to nearest (saturating).
module sqrt_seq #(
    parameter int IN_W   = 8,
    parameter int FRAC_W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    sqrt_seq_if.slave    bus
);
    localparam int OUT_W = IN_W / 2 + FRAC_W;
    localparam int DW    = 2 * OUT_W;          // scaled radicand width
    localparam int RW    = OUT_W + 2;          // partial remainder width
    localparam int CW    = $clog2(OUT_W + 1);  // iteration counter width

`ifdef SQRT_ROUND_EN
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RND = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t           state_q, state_d;
    logic [DW-1:0]    d_q, d_d;
    logic [OUT_W-1:0] q_q, q_d;
    logic [RW-1:0]    r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [OUT_W:0]   rem_q, rem_d;
    logic             exact_q, exact_d;

    logic [RW-1:0]    r_sh;
    logic [RW:0]      trial;

    // Next-state, datapath recurrence and result capture for every state.
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        rem_d   = rem_q;
        exact_d = exact_q;
        // Remainder shifted left by 2 with the next two radicand MSBs appended; the trial
        // subtraction carries one extra bit so its MSB acts as the sign.
        r_sh    = RW'({r_q, d_q[DW-1 -: 2]});
        trial   = {1'b0, r_sh} - {1'b0, q_q, 2'b01};

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    d_d     = DW'(bus.in) << (2 * FRAC_W);
                    q_d     = '0;
                    r_d     = '0;
                    cnt_d   = CW'(OUT_W - 1);
                    state_d = CALC;
                end
            end
            CALC: begin
                d_d = d_q << 2;
                if (!trial[RW]) begin
                    r_d = trial[RW-1:0];
                    q_d = (q_q << 1) | OUT_W'(1);
                end else begin
                    r_d = r_sh;
                    q_d = q_q << 1;
                end
                if (cnt_q == '0) begin
                    out_d   = q_d;
                    rem_d   = r_d[OUT_W:0];
                    exact_d = (r_d == '0);
`ifdef SQRT_ROUND_EN
                    state_d = RND;
`else
                    state_d = DONE;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef SQRT_ROUND_EN
            RND: begin
                // Round up when R > q, i.e. the true root lies above q + 0.5; never wrap.
                if ((rem_q > {1'b0, out_q}) && !(&out_q)) begin
                    out_d = out_q + 1'b1;
                end
                state_d = DONE;
            end
`endif
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation and clears the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            d_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            rem_q   <= '0;
            exact_q <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
            exact_q <= exact_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out       = out_q;
    assign bus.rem       = rem_q;
    assign bus.exact     = exact_q;
endmodule

// File: tb/tb_sqrt_seq.sv
// tb_sqrt_seq: directed and random checks of sqrt_seq against an integer square-root model.
module tb_sqrt_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

`ifdef SQRT_ROUND_EN
    localparam int RND_EN = 1;
`else
    localparam int RND_EN = 0;
`endif
    localparam int LAT0 = 16 + RND_EN;
    localparam int LAT1 = 8 + RND_EN;

    sqrt_seq_if #(.IN_W(8),  .FRAC_W(12)) if0 ();
    sqrt_seq_if #(.IN_W(16), .FRAC_W(0))  if1 ();

    sqrt_seq #(.IN_W(8),  .FRAC_W(12)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    sqrt_seq #(.IN_W(16), .FRAC_W(0))  dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    typedef struct packed {
        logic [15:0] o;
        logic [16:0] r;
        logic        e;
    } exp_t;

    exp_t expq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Largest q with q*q <= v, found bit by bit from the top.
    function automatic longint isqrt(input longint v);
        longint q = 0;
        for (int b = 24; b >= 0; b--) begin
            longint c = q + (longint'(1) << b);
            if (c * c <= v) q = c;
        end
        return q;
    endfunction

    function automatic exp_t model(input logic [7:0] x);
        exp_t   e;
        longint v = longint'(x) << 24;
        longint q = isqrt(v);
        longint r = v - q * q;
        e.r = 17'(r);
        e.e = (r == 0);
`ifdef SQRT_ROUND_EN
        if (r > q && q < 65535) q = q + 1;
`endif
        e.o = 16'(q);
        return e;
    endfunction

    task automatic wait_cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] x);
        int n = 0;
        if0.in       = x;
        if0.in_valid = 1'b1;
        while (!if0.in_ready && n < 50) begin
            wait_cyc();
            n++;
        end
        if (n >= 50) check("accept_timeout", 64'd0, 64'd1);
        wait_cyc();
        if0.in_valid = 1'b0;
    endtask

    task automatic wait_result(output logic [15:0] o, output logic [16:0] r, output logic e);
        int n = 0;
        while (!if0.out_valid && n < 60) begin
            wait_cyc();
            n++;
        end
        if (n >= 60) check("result_timeout", 64'd0, 64'd1);
        o = if0.out;
        r = if0.rem;
        e = if0.exact;
    endtask

    task automatic finish_op();
        if0.out_ready = 1'b1;
        wait_cyc();
        if0.out_ready = 1'b0;
    endtask

    task automatic run(input logic [7:0] x, output logic [15:0] o, output logic [16:0] r,
                       output logic e);
        start_op(x);
        wait_result(o, r, e);
        finish_op();
    endtask

    initial begin
        logic [15:0] o;
        logic [16:0] r;
        logic        e;
        exp_t        m;
        int          n;

        rst_n         = 1'b0;
        if0.in_valid  = 1'b0;
        if0.in        = '0;
        if0.out_ready = 1'b0;
        if1.in_valid  = 1'b0;
        if1.in        = '0;
        if1.out_ready = 1'b0;

        // Compare process: tracks accepted requests and checks every cycle the output is meaningful.
        fork
            begin
                int   cyc      = 0;
                int   acc_cyc  = 0;
                logic prev_vld = 1'b0;
                forever begin
                    @(posedge clk);
                    cyc++;
                    if (!rst_n) begin
                        expq.delete();
                    end else begin
                        if (if0.in_valid && if0.in_ready) begin
                            expq.push_back(model(if0.in));
                            acc_cyc = cyc;
                        end
                        if (if0.out_valid && if0.out_ready && expq.size() > 0) begin
                            void'(expq.pop_front());
                        end
                    end
                    @(negedge clk);
                    if (!rst_n) begin
                        check("rst_out_valid", 64'(if0.out_valid), 64'd0);
                        check("rst_in_ready",  64'(if0.in_ready),  64'd1);
                        check("rst_out",       64'(if0.out),       64'd0);
                        check("rst_rem",       64'(if0.rem),       64'd0);
                        check("rst_exact",     64'(if0.exact),     64'd0);
                        prev_vld = 1'b0;
                    end else if (if0.out_valid) begin
                        if (expq.size() == 0) begin
                            check("spurious_out_valid", 64'd1, 64'd0);
                        end else begin
                            check("cmp_out",   64'(if0.out),   64'(expq[0].o));
                            check("cmp_rem",   64'(if0.rem),   64'(expq[0].r));
                            check("cmp_exact", 64'(if0.exact), 64'(expq[0].e));
                        end
                        check("busy_in_ready", 64'(if0.in_ready), 64'd0);
                        if (!prev_vld) check("latency", 64'(cyc - acc_cyc), 64'(LAT0));
                        prev_vld = 1'b1;
                    end else begin
                        prev_vld = 1'b0;
                    end
                end
            end
        join_none

        // Hand-computed values pinning the model.
        m = model(8'd169);
        check("model_169_out", 64'(m.o), 64'hD000);
        check("model_169_rem", 64'(m.r), 64'd0);
        m = model(8'd82);
        check("model_82_out", 64'(m.o), RND_EN ? 64'h90E3 : 64'h90E2);
        check("model_82_rem", 64'(m.r), 64'd63612);
        m = model(8'd255);
        check("model_255_out", 64'(m.o), RND_EN ? 64'hFF80 : 64'hFF7F);
        check("isqrt_65535", 64'(isqrt(64'd65535)), 64'd255);

        repeat (3) wait_cyc();
        rst_n = 1'b1;
        wait_cyc();

        run(8'd169, o, r, e);
        check("d169_out", 64'(o), 64'hD000);
        check("d169_rem", 64'(r), 64'd0);
        check("d169_exact", 64'(e), 64'd1);
        run(8'd64, o, r, e);
        check("d64_out", 64'(o), 64'h8000);
        check("d64_exact", 64'(e), 64'd1);
        run(8'd25, o, r, e);
        check("d25_out", 64'(o), 64'h5000);
        check("d25_exact", 64'(e), 64'd1);
        run(8'd82, o, r, e);
        check("d82_out", 64'(o), RND_EN ? 64'h90E3 : 64'h90E2);
        check("d82_exact", 64'(e), 64'd0);
        check("d82_rem", 64'(r), 64'd63612);
        run(8'd0, o, r, e);
        check("d0_out", 64'(o), 64'd0);
        check("d0_rem", 64'(r), 64'd0);
        check("d0_exact", 64'(e), 64'd1);
        run(8'd255, o, r, e);
        check("d255_out", 64'(o), RND_EN ? 64'hFF80 : 64'hFF7F);

        // Backpressure on in=25, then release together with a new request.
        start_op(8'd25);
        wait_result(o, r, e);
        for (int i = 0; i < 10; i++) begin
            wait_cyc();
            check("bp_out_valid", 64'(if0.out_valid), 64'd1);
            check("bp_out",       64'(if0.out),       64'h5000);
            check("bp_in_ready",  64'(if0.in_ready),  64'd0);
        end
        if0.out_ready = 1'b1;
        if0.in_valid  = 1'b1;
        if0.in        = 8'd64;
        wait_cyc();
        if0.out_ready = 1'b0;
        check("same_cycle_not_accepted", 64'(if0.in_ready), 64'd1);
        check("same_cycle_out_valid", 64'(if0.out_valid), 64'd0);
        wait_cyc();
        if0.in_valid = 1'b0;
        check("accepted_next_cycle", 64'(if0.in_ready), 64'd0);
        wait_result(o, r, e);
        check("bp64_out", 64'(o), 64'h8000);
        finish_op();

        // Reset during iteration 7 of in=169.
        start_op(8'd169);
        repeat (6) wait_cyc();
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(if0.out_valid), 64'd0);
        check("abort_out",       64'(if0.out),       64'd0);
        check("abort_rem",       64'(if0.rem),       64'd0);
        check("abort_exact",     64'(if0.exact),     64'd0);
        check("abort_in_ready",  64'(if0.in_ready),  64'd1);
        repeat (2) wait_cyc();
        rst_n = 1'b1;
        repeat (3) wait_cyc();
        check("post_abort_no_valid", 64'(if0.out_valid), 64'd0);
        run(8'd64, o, r, e);
        check("post_abort_64", 64'(o), 64'h8000);

        // Random radicands, checked by the compare process.
        for (int i = 0; i < 20; i++) begin
            run(8'($urandom_range(0, 255)), o, r, e);
        end

        // Wide-input, integer-only instance; the rounded result would saturate at 255.
        if1.in       = 16'hFFFF;
        if1.in_valid = 1'b1;
        wait_cyc();
        if1.in_valid = 1'b0;
        n = 0;
        while (!if1.out_valid && n < 40) begin
            wait_cyc();
            n++;
        end
        check("w16_latency", 64'(n), 64'(LAT1));
        check("w16_out",   64'(if1.out),   64'd255);
        check("w16_rem",   64'(if1.rem),   64'd510);
        check("w16_exact", 64'(if1.exact), 64'd0);
        if1.out_ready = 1'b1;
        wait_cyc();
        if1.out_ready = 1'b0;
        check("w16_released", 64'(if1.out_valid), 64'd0);

        repeat (2) wait_cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
